sbus_slave_port: RTL and testbench
==================================

SBUS_SLAVE_PORT -- requirements
Module: sbus_slave_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, memory address width in bits.
REQ-002 Parameter DATA_WIDTH, default 8, memory data width in bits.
REQ-003 Parameter LANES, default 1, serial lanes per beat; ADDR_WIDTH and DATA_WIDTH SHALL be integer multiples of LANES.
REQ-004 Parameter MEM_LATENCY, default 1, slave memory read latency in cycles, range 1..8.
REQ-005 Parameter MEM_DEPTH, default 2**ADDR_WIDTH, number of valid words; addresses >= MEM_DEPTH are out of range.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 rstn  input  1  asynchronous, active-low reset.
REQ-008 swdata  input  LANES  address/write-data beat from master, LSB-first.
REQ-009 smode  input  1  0 read, 1 write; sampled only on the first address beat.
REQ-010 mvalid  input  1  swdata beat valid.
REQ-011 srdata  output  LANES  read-data beat to master, LSB-first.
REQ-012 svalid  output  1  srdata beat valid.
REQ-013 sready  output  1  port idle, ready for a new transaction.
REQ-014 serr  output  1  out-of-range access indication.
REQ-015 smemrdata  input  DATA_WIDTH  read data from slave memory.
REQ-016 smemaddr  output  ADDR_WIDTH  memory address.
REQ-017 smemwdata  output  DATA_WIDTH  memory write data.
REQ-018 smemwen, smemren  output  1 each  memory write / read enables.

Function
REQ-019 States SHALL be IDLE, ADDR, WDATA, MEMW, MEMR, RDATA; sready SHALL be 1 exactly when state is IDLE.
REQ-020 Beat k of a field SHALL carry bits [k*LANES +: LANES]; address takes ADDR_WIDTH/LANES beats, data DATA_WIDTH/LANES beats.
REQ-021 IDLE with mvalid=1: capture beat 0 and smode; -> ADDR, or directly to WDATA/MEMR when address is a single beat.
REQ-022 ADDR/WDATA: a beat is consumed only on cycles with mvalid=1; mvalid=0 holds state, counter and captured bits (gaps allowed).
REQ-023 After last address beat: smode=1 -> WDATA, smode=0 -> MEMR.
REQ-024 After last write-data beat -> MEMW; MEMW lasts exactly 1 cycle with smemwen=1, smemaddr=captured address, smemwdata=captured data, then -> IDLE.
REQ-025 MEMR SHALL last MEM_LATENCY+1 cycles with smemren=1 and smemaddr valid throughout; smemrdata SHALL be registered on the final MEMR edge; then -> RDATA.
REQ-026 RDATA SHALL present DATA_WIDTH/LANES consecutive beats with svalid=1 and no stall, then -> IDLE with svalid=0.
REQ-027 mvalid SHALL be ignored in MEMW, MEMR and RDATA.
REQ-028 Out-of-range write: MEMW occurs with smemwen=0 and serr=1 for that cycle; memory untouched.
REQ-029 Out-of-range read: smemren stays 0 in MEMR, RDATA beats are all zero, serr=1 for every RDATA cycle.
REQ-030 serr SHALL be 0 in all other cycles; smemwen and smemren SHALL never both be 1.
REQ-031 All outputs except sready SHALL be registered; sready decodes from state register only.

Reset
REQ-032 rstn=0 SHALL immediately force IDLE, beat counter 0, captured address/data/mode 0, independent of clk.
REQ-033 Reset values: sready=1; svalid, serr, smemwen, smemren=0; srdata, smemaddr, smemwdata=0.
REQ-034 Reset asserted mid-transaction SHALL abandon it with no memory enable pulse after deassertion.
REQ-035 After rstn rises, the first mvalid=1 cycle SHALL be treated as beat 0 of a new transaction.

Verification (LANES=2, ADDR_WIDTH=12, DATA_WIDTH=8, MEM_LATENCY=2, MEM_DEPTH=2048)
REQ-036 Write 0xA5 to 0x123: addr beats 3,0,2,0,1,0, data beats 1,1,2,2 -> one cycle smemwen=1, smemaddr=0x123, smemwdata=0xA5, then sready=1.
REQ-037 Read 0x123 with memory returning 0x3C -> smemren=1 for 3 cycles, then svalid=1 for 4 cycles with srdata 0,3,3,0, then sready=1.
REQ-038 Write with mvalid low for 3 cycles between address beats 2 and 3 -> same result as REQ-036, latency +3 cycles.
REQ-039 Read 0xA00 (out of range) -> smemren never 1, srdata 0,0,0,0 with serr=1 and svalid=1 for 4 cycles.
REQ-040 rstn pulsed low after 2 write-data beats -> immediate IDLE, sready=1, no smemwen pulse; next write completes normally.
REQ-041 LANES=1 build, write 0x5A to 0x001 -> 12 address + 8 data beats, smemwdata=0x5A, smemaddr=0x001.

Source files
------------

// File: rtl/sbus_slave_port.sv
// Serial-bus slave port: deserialises address/write data beats from the master,
// drives a simple synchronous memory and serialises read data back LSB-first.
module sbus_slave_port #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          DATA_WIDTH  = 8,
  parameter int          LANES       = 1,
  parameter int          MEM_LATENCY = 1,
  parameter int unsigned MEM_DEPTH   = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [LANES-1:0]      swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic [LANES-1:0]      srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  serr,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  output logic                  smemwen,
  output logic                  smemren
);

  localparam int unsigned ABEATS = ADDR_WIDTH / LANES;
  localparam int unsigned DBEATS = DATA_WIDTH / LANES;
  localparam int unsigned MAXC0  = (ABEATS > DBEATS) ? ABEATS : DBEATS;
  localparam int unsigned MAXC   = (MAXC0 > MEM_LATENCY + 1) ? MAXC0 : MEM_LATENCY + 1;
  localparam int          CW     = $clog2(MAXC + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = MEM_DEPTH[ADDR_WIDTH:0];

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEMW, MEMR, RDATA} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rsh_q, rsh_d;
  logic                  mode_q, mode_d;
  logic                  in_rng;

  logic [LANES-1:0]      srdata_d;
  logic                  svalid_d, serr_d, wen_d, ren_d;
  logic [ADDR_WIDTH-1:0] maddr_d;
  logic [DATA_WIDTH-1:0] mwdata_d;

  assign sready = (state == IDLE);
  assign in_rng = ({1'b0, addr_d} < DEPTH_LIM);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    data_d  = data_q;
    mode_d  = mode_q;
    rsh_d   = rsh_q;
    unique case (state)
      IDLE: begin
        if (mvalid) begin
          addr_d             = '0;
          addr_d[LANES-1:0]  = swdata;
          data_d             = '0;
          mode_d             = smode;
          if (ABEATS == 1) begin
            state_d = smode ? WDATA : MEMR;
            cnt_d   = '0;
          end else begin
            state_d = ADDR;
            cnt_d   = CW'(1);
          end
        end
      end
      ADDR: begin
        if (mvalid) begin
          for (int unsigned k = 0; k < ABEATS; k++)
            if (cnt == CW'(k)) addr_d[k*LANES +: LANES] = swdata;
          if (cnt == CW'(ABEATS - 1)) begin
            state_d = mode_q ? WDATA : MEMR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      WDATA: begin
        if (mvalid) begin
          for (int unsigned k = 0; k < DBEATS; k++)
            if (cnt == CW'(k)) data_d[k*LANES +: LANES] = swdata;
          if (cnt == CW'(DBEATS - 1)) begin
            state_d = MEMW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      MEMW: state_d = IDLE;
      MEMR: begin
        // Final MEMR edge: memory data is valid now; out-of-range reads return zero.
        if (cnt == CW'(MEM_LATENCY)) begin
          state_d = RDATA;
          cnt_d   = '0;
          rsh_d   = in_rng ? smemrdata : '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RDATA: begin
        if (cnt == CW'(DBEATS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
          rsh_d = rsh_q >> LANES;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they are registered yet
  // line up with the state they belong to; memory address/data hold otherwise.
  always_comb begin
    wen_d    = (state_d == MEMW) && in_rng;
    ren_d    = (state_d == MEMR) && in_rng;
    serr_d   = ((state_d == MEMW) || (state_d == RDATA)) && !in_rng;
    svalid_d = (state_d == RDATA);
    srdata_d = svalid_d ? rsh_d[LANES-1:0] : '0;
    maddr_d  = ((state_d == MEMW) || (state_d == MEMR)) ? addr_d : smemaddr;
    mwdata_d = (state_d == MEMW) ? data_d : smemwdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rsh_q     <= '0;
      mode_q    <= 1'b0;
      srdata    <= '0;
      svalid    <= 1'b0;
      serr      <= 1'b0;
      smemaddr  <= '0;
      smemwdata <= '0;
      smemwen   <= 1'b0;
      smemren   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rsh_q     <= rsh_d;
      mode_q    <= mode_d;
      srdata    <= srdata_d;
      svalid    <= svalid_d;
      serr      <= serr_d;
      smemaddr  <= maddr_d;
      smemwdata <= mwdata_d;
      smemwen   <= wen_d;
      smemren   <= ren_d;
    end
  end

endmodule

// File: tb/tb_sbus_slave_port.sv
// Bench for sbus_slave_port: per-cycle expectations built from transaction
// descriptions, plus directed literal checks and a LANES=1 build.
module tb_sbus_slave_port;
  localparam int AW = 12, DW = 8, LN = 2, LAT = 2, DEPTH = 2048;
  localparam int AB = AW / LN, DB = DW / LN;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [LN-1:0] swdata, srdata;
  logic          smode, mvalid, svalid, sready, serr, smemwen, smemren;
  logic [DW-1:0] smemrdata, smemwdata;
  logic [AW-1:0] smemaddr;

  logic [0:0]    swdata1, srdata1;
  logic          smode1, mvalid1, svalid1, sready1, serr1, smemwen1, smemren1;
  logic [DW-1:0] smemrdata1, smemwdata1;
  logic [AW-1:0] smemaddr1;

  sbus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN),
                    .MEM_LATENCY(LAT), .MEM_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready), .serr(serr),
    .smemrdata(smemrdata), .smemaddr(smemaddr), .smemwdata(smemwdata),
    .smemwen(smemwen), .smemren(smemren));

  sbus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(1),
                    .MEM_LATENCY(1), .MEM_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rstn(rstn), .swdata(swdata1), .smode(smode1), .mvalid(mvalid1),
    .srdata(srdata1), .svalid(svalid1), .sready(sready1), .serr(serr1),
    .smemrdata(smemrdata1), .smemaddr(smemaddr1), .smemwdata(smemwdata1),
    .smemwen(smemwen1), .smemren(smemren1));

  typedef struct {
    logic          ready, svalid, serr, wen, ren;
    logic [LN-1:0] rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0, errors = 0;
  int            wen_cnt = 0, ren_cnt = 0, serr_cnt = 0;
  logic [AW-1:0] last_waddr;
  logic [DW-1:0] last_wdata;
  logic [LN-1:0] beats[$];
  logic [DW-1:0] mem[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic ready);
    exp_t e;
    e = '{default: '0};
    e.ready = ready;
    return e;
  endfunction

  // One expectation per rising edge, describing the outputs after that edge.
  task automatic tick(input exp_t e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_stats();
    wen_cnt = 0; ren_cnt = 0; serr_cnt = 0;
    beats.delete();
  endtask

  task automatic rand_ignored();
    mvalid    = 1'($urandom);
    swdata    = LN'($urandom);
    smode     = 1'($urandom);
    smemrdata = DW'($urandom);
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (smemwen) begin wen_cnt++; last_waddr = smemaddr; last_wdata = smemwdata; end
        if (smemren) ren_cnt++;
        if (svalid)  beats.push_back(srdata);
        if (serr)    serr_cnt++;
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sready",  sready,  e.ready);
        chk("svalid",  svalid,  e.svalid);
        chk("serr",    serr,    e.serr);
        chk("smemwen", smemwen, e.wen);
        chk("smemren", smemren, e.ren);
        if (e.svalid)         chk("srdata",    srdata,    e.rdata);
        if (e.wen || e.ren)   chk("smemaddr",  smemaddr,  e.addr);
        if (e.wen)            chk("smemwdata", smemwdata, e.wdata);
      end
    end
  end

  task automatic reset_values(input string tag);
    chk({tag, " sready"}, sready, 1);
    chk({tag, " svalid"}, svalid, 0);
    chk({tag, " serr"}, serr, 0);
    chk({tag, " smemwen"}, smemwen, 0);
    chk({tag, " smemren"}, smemren, 0);
    chk({tag, " srdata"}, srdata, 0);
    chk({tag, " smemaddr"}, smemaddr, 0);
    chk({tag, " smemwdata"}, smemwdata, 0);
    chk({tag, " sready1"}, sready1, 1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 rstn = 1'b0;
    #1 reset_values("midreset");
    mvalid = 1'b0;
    #1 rstn = 1'b1;
  endtask

  // Drives one transaction and queues the cycle-by-cycle outputs it must produce.
  task automatic do_txn(input bit mode, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int gap_at, input int gap_len, input bit rgaps, input int abort_at);
    bit   inr;
    exp_t e;
    int   ng;
    inr = (a < DEPTH);
    for (int k = 0; k < AB; k++) begin
      ng = (k == gap_at) ? gap_len : 0;
      if (rgaps && k > 0 && $urandom_range(3) == 0) ng += int'($urandom_range(3, 1));
      for (int g = 0; g < ng; g++) begin
        mvalid = 1'b0; swdata = LN'($urandom); smode = 1'($urandom);
        tick(mk(k == 0));
      end
      mvalid = 1'b1;
      swdata = a[k*LN +: LN];
      smode  = (k == 0) ? mode : 1'($urandom);
      e = mk(0);
      if (k == AB - 1 && !mode) begin e.ren = inr; e.addr = a; end
      tick(e);
    end
    if (mode) begin
      for (int k = 0; k < DB; k++) begin
        ng = (rgaps && $urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
        for (int g = 0; g < ng; g++) begin
          mvalid = 1'b0; swdata = LN'($urandom); smode = 1'($urandom);
          tick(mk(0));
        end
        mvalid = 1'b1;
        swdata = d[k*LN +: LN];
        smode  = 1'($urandom);
        e = mk(0);
        if (k == DB - 1) begin e.wen = inr; e.serr = !inr; e.addr = a; e.wdata = d; end
        tick(e);
        if (k + 1 == abort_at) begin
          reset_pulse();
          return;
        end
      end
      if (inr) mem[int'(a)] = d;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        rand_ignored();
        e = mk(0); e.ren = inr; e.addr = a;
        tick(e);
      end
      for (int j = 0; j < DB; j++) begin
        rand_ignored();
        if (j == 0) smemrdata = d;
        e = mk(0); e.svalid = 1'b1; e.serr = !inr;
        e.rdata = inr ? d[j*LN +: LN] : '0;
        tick(e);
      end
    end
    rand_ignored();
    tick(mk(1));
    mvalid = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [LN-1:0] expb[4];
    logic [AW-1:0] a1;
    logic [DW-1:0] d1, rd;
    logic [AW-1:0] ra;
    bit            rm;
    mvalid = 1'b0; swdata = '0; smode = 1'b0; smemrdata = '0;
    mvalid1 = 1'b0; swdata1 = '0; smode1 = 1'b0; smemrdata1 = '0;
    #2 reset_values("reset");
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    repeat (2) tick(mk(1));

    // Write 0xA5 to 0x123
    clr_stats();
    do_txn(1'b1, 12'h123, 8'hA5, -1, 0, 1'b0, -1);
    settle();
    chk("wr123 pulses", wen_cnt, 1);
    chk("wr123 addr", last_waddr, 12'h123);
    chk("wr123 data", last_wdata, 8'hA5);
    chk("wr123 sready", sready, 1);

    // Read 0x123 with memory returning 0x3C
    clr_stats();
    do_txn(1'b0, 12'h123, 8'h3C, -1, 0, 1'b0, -1);
    settle();
    expb = '{2'd0, 2'd3, 2'd3, 2'd0};
    chk("rd123 ren cycles", ren_cnt, 3);
    chk("rd123 beat count", beats.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("rd123 beat", (i < beats.size()) ? beats[i] : 2'bxx, expb[i]);
    chk("rd123 serr cycles", serr_cnt, 0);
    chk("rd123 sready", sready, 1);

    // Write with a 3-cycle mvalid gap inside the address
    clr_stats();
    do_txn(1'b1, 12'h123, 8'hA5, 3, 3, 1'b0, -1);
    settle();
    chk("gapwr pulses", wen_cnt, 1);
    chk("gapwr addr", last_waddr, 12'h123);
    chk("gapwr data", last_wdata, 8'hA5);

    // Out-of-range read
    clr_stats();
    do_txn(1'b0, 12'hA00, 8'h77, -1, 0, 1'b0, -1);
    settle();
    chk("oor ren cycles", ren_cnt, 0);
    chk("oor serr cycles", serr_cnt, 4);
    chk("oor beat count", beats.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("oor beat", (i < beats.size()) ? beats[i] : 2'bxx, 0);

    // Reset after two write-data beats, then a normal write
    clr_stats();
    do_txn(1'b1, 12'h2F0, 8'h5C, -1, 0, 1'b0, 2);
    repeat (3) tick(mk(1));
    settle();
    chk("abort pulses", wen_cnt, 0);
    do_txn(1'b1, 12'h2F0, 8'h5C, -1, 0, 1'b0, -1);
    settle();
    chk("after abort pulses", wen_cnt, 1);
    chk("after abort addr", last_waddr, 12'h2F0);
    chk("after abort data", last_wdata, 8'h5C);

    // LANES=1 build: write 0x5A to 0x001
    a1 = 12'h001; d1 = 8'h5A;
    for (int k = 0; k < AW + DW; k++) begin
      mvalid1 = 1'b1;
      swdata1 = (k < AW) ? a1[k] : d1[k - AW];
      smode1  = (k == 0) ? 1'b1 : 1'($urandom);
      tick(mk(1));
      if (k < AW + DW - 1) begin
        chk("l1 sready busy", sready1, 0);
        chk("l1 no early wen", smemwen1, 0);
      end
    end
    chk("l1 wen", smemwen1, 1);
    chk("l1 addr", smemaddr1, 12'h001);
    chk("l1 wdata", smemwdata1, 8'h5A);
    chk("l1 serr", serr1, 0);
    chk("l1 ren", smemren1, 0);
    mvalid1 = 1'b0;
    tick(mk(1));
    chk("l1 sready after", sready1, 1);
    chk("l1 wen after", smemwen1, 0);
    chk("l1 svalid", svalid1, 0);
    chk("l1 srdata", srdata1, 0);

    // Randomised traffic
    repeat (60) begin
      rm = 1'($urandom);
      ra = AW'($urandom);
      if (rm) rd = DW'($urandom);
      else    rd = mem.exists(int'(ra)) ? mem[int'(ra)] : DW'($urandom);
      do_txn(rm, ra, rd, -1, 0, 1'b1, -1);
      repeat ($urandom_range(2)) tick(mk(1));
    end

    repeat (2) tick(mk(1));
    settle();
    chk("expectations drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
